// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constant helpers for the keypad scanner.
//   kp_state_e : scanner FSM state encoding
//   code_w()   : width of a key code for a ROWS x COLS matrix
//   cnt_w()    : width of an unsigned counter that must hold 0..max_val
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_HELD     = 3'd3,
    ST_RELEASE  = 3'd4
  } kp_state_e;

  function automatic int code_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// -----------------------------------------------------------------------------
// keypad_event_fifo
// Small synchronous FIFO for key events with a registered head-of-queue.
//   clk_sys  in   system clock
//   rst_n    in   asynchronous active-low reset
//   push_i   in   write din_i (dropped when full unless a pop happens too)
//   pop_i    in   remove head (ignored when empty)
//   din_i    in   WIDTH event data
//   dout_o   out  WIDTH registered head entry
//   valid_o  out  registered "not empty"
//   count_o  out  entries held, 0..DEPTH
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
// -----------------------------------------------------------------------------
module keypad_event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CNW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q;
  logic             full, empty, do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNW'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still lands when the consumer is draining.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;

    // Head register tracks mem_q[rd] one cycle ahead so the output is a flop.
    head_d = head_q;
    if (do_push && (empty || (do_pop && cnt_q == CNW'(1)))) head_d = din_i;
    else if (do_pop && cnt_q > CNW'(1))                     head_d = mem_q[rd_q + 1'b1];
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= (cnt_d != '0);
    end
  end

  assign dout_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = cnt_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
// Row-scanning matrix keypad controller with debounce and an event FIFO.
//   CLOCK_50      in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   keypad_column in   COLS column sense, active-low, asynchronous
//   keypad_row    out  ROWS row drive, active-low
//   key_valid     out  FIFO not empty
//   key_code      out  head-of-FIFO code = row*COLS + col
//   key_pop       in   consume head (ignored when empty)
//   fifo_count    out  events buffered
//   overflow      out  sticky, set when an accepted press finds the FIFO full
//   overflow_clr  in   clear overflow (a same-cycle set wins)
//   irq           out  key_valid | overflow
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | all rows driven low, waiting for any column to go low
// SCAN     | one row driven, settle then sample; advance row or latch key
// DEBOUNCE | latched column must stay low DEBOUNCE_CYC samples, then push
// HELD     | key accepted, waiting for latched column to go high
// RELEASE  | latched column must stay high DEBOUNCE_CYC samples, then IDLE
// -----------------------------------------------------------------------------
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SETTLE_CYC   = 500,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int FIFO_DEPTH   = 8,
  parameter int REPEAT_CYC   = 25000000
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [COLS-1:0]               keypad_column,
  output logic [ROWS-1:0]               keypad_row,
  output logic                          key_valid,
  output logic [code_w(ROWS, COLS)-1:0] key_code,
  input  logic                          key_pop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          irq
);

  localparam int CW   = code_w(ROWS, COLS);
  localparam int RW   = cnt_w(ROWS - 1);
  localparam int CLW  = cnt_w(COLS - 1);
  localparam int TMAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
  localparam int TW   = cnt_w(TMAX);

  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] DEB_LD    = TW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  // Settle must cover the two-flop synchroniser plus the row drive flop.
  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SETTLE_CYC < 3 ||
      DEBOUNCE_CYC < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      REPEAT_CYC < 1) begin : g_bad_param
    $error("keypad_scan_ctrl: parameter out of range");
  end

  logic [COLS-1:0] col_s1_q, col_s2_q;
  kp_state_e       state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CLW-1:0]  col_q, col_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [ROWS-1:0] row_drv_q, row_drv_d;
  logic            overflow_q, overflow_d;
  logic            any_low, lat_low, push_first, push;
  logic [CLW-1:0]  low_col;
  logic            fifo_full, fifo_empty, pop_ok, ovf_set;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      col_s1_q <= '1;
      col_s2_q <= '1;
    end else begin
      col_s1_q <= keypad_column;
      col_s2_q <= col_s1_q;
    end
  end

  // Descending loop so the lowest low column is the last (winning) assignment.
  always_comb begin
    any_low = ~&col_s2_q;
    low_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_s2_q[c]) low_col = CLW'(c);
    end
  end

  assign lat_low = ~col_s2_q[col_q];

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    tmr_d      = tmr_q;
    push_first = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_low) begin
          state_d = ST_SCAN;
          row_d   = '0;
          tmr_d   = SETTLE_LD;
        end
      end
      ST_SCAN: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (any_low) begin
          state_d = ST_DEBOUNCE;
          col_d   = low_col;
          tmr_d   = DEB_LD;
        end else if (row_q == ROW_LAST) begin
          state_d = ST_IDLE;
        end else begin
          row_d = row_q + 1'b1;
          tmr_d = SETTLE_LD;
        end
      end
      ST_DEBOUNCE: begin
        if (!lat_low) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          push_first = 1'b1;
          state_d    = ST_HELD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_HELD: begin
        if (!lat_low) begin
          state_d = ST_RELEASE;
          tmr_d   = DEB_LD;
        end
      end
      ST_RELEASE: begin
        if (lat_low) begin
          state_d = ST_HELD;
        end else if (tmr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    row_drv_d = (state_d == ST_IDLE) ? '0 : ~(ROWS'(1) << row_d);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      tmr_q     <= '0;
      row_drv_q <= '1;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      tmr_q     <= tmr_d;
      row_drv_q <= row_drv_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int              RPW    = cnt_w(REPEAT_CYC);
  localparam logic [RPW-1:0]  REP_LD = RPW'(REPEAT_CYC - 1);

  logic [RPW-1:0] rep_q, rep_d;
  logic           rep_push;

  // Keeps counting through a RELEASE bounce; if it expires there the repeat
  // fires as soon as the key is seen held again.
  always_comb begin
    rep_d    = rep_q;
    rep_push = 1'b0;
    if (push_first) begin
      rep_d = REP_LD;
    end else if (state_q == ST_HELD && lat_low && rep_q == '0) begin
      rep_push = 1'b1;
      rep_d    = REP_LD;
    end else if ((state_q == ST_HELD || state_q == ST_RELEASE) && rep_q != '0) begin
      rep_d = rep_q - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) rep_q <= '0;
    else        rep_q <= rep_d;
  end

  assign push = push_first | rep_push;
`else
  assign push = push_first;
`endif

  keypad_event_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (CLOCK_50),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (key_pop),
    .din_i   (CW'(row_q * COLS + col_q)),
    .dout_o  (key_code),
    .valid_o (key_valid),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop_ok     = key_pop & ~fifo_empty;
  assign ovf_set    = push & fifo_full & ~pop_ok;
  assign overflow_d = ovf_set ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign keypad_row = row_drv_q;
  assign overflow   = overflow_q;
  assign irq        = key_valid | overflow_q;

endmodule
